// File: rtl/rdret.sv
// rdret: read-return router behind the bank-conflict read arbiter.
// Issues the chosen read to the banked scratchpad, carries its source code
// through the fixed memory latency, and steers returned data to i/d/c.
// Handshake: a request is taken whenever en=1 with a legal muxcode; there is
// no ready/backpressure, and each x_rvalid is a single-cycle pulse qualifying
// x_rdata in that same cycle.
module rdret #(
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int DATABITS = 64,
  parameter int RDLAT    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [BANKBITS+WORDBITS-1:0] addr,
  input  logic [1:0]                   muxcode,
  output logic                         mem_en,
  output logic [BANKBITS+WORDBITS-1:0] mem_addr,
  input  logic [DATABITS-1:0]          mem_rdata,
  output logic                         i_rvalid,
  output logic                         d_rvalid,
  output logic                         c_rvalid,
  output logic [DATABITS-1:0]          i_rdata,
  output logic [DATABITS-1:0]          d_rdata,
  output logic [DATABITS-1:0]          c_rdata,
  output logic                         busy,
  output logic                         err
);

  localparam int CW = $clog2(RDLAT + 3);

  // muxcode 3 is never forwarded to memory and never tagged
  logic accept;
  assign accept = en && (muxcode != 2'd3);

  // Tag pipeline: stage k holds the request issued k+1 cycles ago, so stage
  // RDLAT lines up with the cycle its mem_rdata is on the bus.
  logic [RDLAT:0]      tag_v;
  logic [RDLAT:0][1:0] tag_c;
  logic                ret_v;
  logic [1:0]          ret_c;
  assign ret_v = tag_v[RDLAT];
  assign ret_c = tag_c[RDLAT];

  // Reads in flight: issued but whose return pulse has not yet been shown
  logic [CW-1:0] count;
  logic          any_ret;
  assign any_ret = i_rvalid || d_rvalid || c_rvalid;
  assign busy    = (count != '0);

  // Issue stage: register the strobe; the address only moves on a real issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_en <= accept;
      if (accept) mem_addr <= addr;
    end
  end

  // Sticky flag for any illegal muxcode seen since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (en && (muxcode == 2'd3)) err <= 1'b1;
  end

  // Tag shift register advances every cycle regardless of traffic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_c <= '0;
    end else begin
      tag_v <= {tag_v[RDLAT-1:0], accept};
      tag_c <= {tag_c[RDLAT-1:0], muxcode};
    end
  end

  // Return stage: pulse the owning requester and latch its data; others hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      c_rdata  <= '0;
    end else begin
      i_rvalid <= ret_v && (ret_c == 2'd0);
      d_rvalid <= ret_v && (ret_c == 2'd1);
      c_rvalid <= ret_v && (ret_c == 2'd2);
      if (ret_v && (ret_c == 2'd0)) i_rdata <= mem_rdata;
      if (ret_v && (ret_c == 2'd1)) d_rdata <= mem_rdata;
      if (ret_v && (ret_c == 2'd2)) c_rdata <= mem_rdata;
    end
  end

  // Outstanding counter: up on issue, down while a return pulse is showing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (accept && !any_ret) begin
      count <= count + CW'(1);
    end else if (!accept && any_ret) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_rdret.sv
// Bench for rdret: three instances (RDLAT 2, 1, 8) share one stimulus stream.
// A request-history model derives every expected output per cycle; directed
// sequences on the RDLAT=2 instance pin literal values.
module tb_rdret;

  localparam int A  = 14;
  localparam int DW = 64;
  localparam int HN = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [A-1:0]  addr;
  logic [1:0]    muxcode;
  logic [DW-1:0] mem_rdata;

  logic [2:0]         mem_en_v, i_rv, d_rv, c_rv, busy_v, err_v;
  logic [2:0][A-1:0]  maddr;
  logic [2:0][DW-1:0] i_rd, d_rd, c_rd;

  int n_tests = 0;
  int n_fail  = 0;
  int lat [3] = '{2, 1, 8};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  rdret #(.RDLAT(2)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .muxcode(muxcode),
    .mem_en(mem_en_v[0]), .mem_addr(maddr[0]), .mem_rdata(mem_rdata),
    .i_rvalid(i_rv[0]), .d_rvalid(d_rv[0]), .c_rvalid(c_rv[0]),
    .i_rdata(i_rd[0]), .d_rdata(d_rd[0]), .c_rdata(c_rd[0]),
    .busy(busy_v[0]), .err(err_v[0])
  );

  rdret #(.RDLAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .muxcode(muxcode),
    .mem_en(mem_en_v[1]), .mem_addr(maddr[1]), .mem_rdata(mem_rdata),
    .i_rvalid(i_rv[1]), .d_rvalid(d_rv[1]), .c_rvalid(c_rv[1]),
    .i_rdata(i_rd[1]), .d_rdata(d_rd[1]), .c_rdata(c_rd[1]),
    .busy(busy_v[1]), .err(err_v[1])
  );

  rdret #(.RDLAT(8)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .muxcode(muxcode),
    .mem_en(mem_en_v[2]), .mem_addr(maddr[2]), .mem_rdata(mem_rdata),
    .i_rvalid(i_rv[2]), .d_rvalid(d_rv[2]), .c_rvalid(c_rv[2]),
    .i_rdata(i_rd[2]), .d_rdata(d_rd[2]), .c_rdata(c_rd[2]),
    .busy(busy_v[2]), .err(err_v[2])
  );

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History per rising edge: accepted request, its code, and the bus data.
  bit            h_acc  [HN];
  logic [1:0]    h_code [HN];
  logic [DW-1:0] h_rd   [HN];
  int            cyc      = 0;
  int            last_rst = -100;
  logic [A-1:0]  exp_addr = '0;
  bit            exp_err  = 1'b0;
  logic [DW-1:0] exp_rd [3][3];

  function automatic int dut_count(input int k);
    case (k)
      0:       return int'(u_dut0.count);
      1:       return int'(u_dut1.count);
      default: return int'(u_dut2.count);
    endcase
  endfunction

  task automatic check_inst(input int k, input int n);
    int         L, t, cnt;
    bit         pulse;
    logic [1:0] code;
    string      p;
    L     = lat[k];
    p     = $sformatf("L%0d_", L);
    t     = n - L - 1;
    pulse = 1'b0;
    code  = 2'd0;
    // A return is due for the request taken L+1 edges ago, unless reset hit it
    if (t >= 1) begin
      if (h_acc[t] && (t > last_rst)) begin
        pulse = 1'b1;
        code  = h_code[t];
      end
    end
    if (last_rst == n) for (int r = 0; r < 3; r++) exp_rd[k][r] = '0;
    if (pulse) exp_rd[k][code] = h_rd[n];
    // In flight: requests taken in the last L+2 edges with no reset since
    cnt = 0;
    for (int s = n - L - 1; s <= n; s++)
      if (s >= 1 && h_acc[s] && s > last_rst) cnt++;
    chk({p, "mem_en"},   mem_en_v[k], h_acc[n]);
    chk({p, "mem_addr"}, maddr[k], exp_addr);
    chk({p, "i_rvalid"}, i_rv[k], pulse && code == 2'd0);
    chk({p, "d_rvalid"}, d_rv[k], pulse && code == 2'd1);
    chk({p, "c_rvalid"}, c_rv[k], pulse && code == 2'd2);
    chk({p, "i_rdata"},  i_rd[k], exp_rd[k][0]);
    chk({p, "d_rdata"},  d_rd[k], exp_rd[k][1]);
    chk({p, "c_rdata"},  c_rd[k], exp_rd[k][2]);
    chk({p, "busy"},     busy_v[k], cnt != 0);
    chk({p, "err"},      err_v[k], exp_err);
    chk({p, "count"},    dut_count(k), cnt);
    chk({p, "count_bound"}, dut_count(k) <= L + 2, 1'b1);
  endtask

  // Record each edge's inputs, then compare all instances just after it
  always @(posedge clk) begin
    int n;
    cyc = cyc + 1;
    n   = cyc;
    if (n < HN) begin
      h_acc[n]  = !rst && en && (muxcode != 2'd3);
      h_code[n] = muxcode;
      h_rd[n]   = mem_rdata;
      if (rst) begin
        last_rst = n;
        exp_addr = '0;
        exp_err  = 1'b0;
      end else begin
        if (h_acc[n]) exp_addr = addr;
        if (en && muxcode == 2'd3) exp_err = 1'b1;
      end
    end
    #1;
    if (n < HN) for (int k = 0; k < 3; k++) check_inst(k, n);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    mem_rdata = {$urandom, $urandom};
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_en"},   mem_en_v[0], 1'b0);
    chk({tag, "_mem_addr"}, maddr[0], '0);
    chk({tag, "_rvalids"},  {i_rv[0], d_rv[0], c_rv[0]}, 3'b000);
    chk({tag, "_i_rdata"},  i_rd[0], '0);
    chk({tag, "_d_rdata"},  d_rd[0], '0);
    chk({tag, "_c_rdata"},  c_rd[0], '0);
    chk({tag, "_busy"},     busy_v[0], 1'b0);
    chk({tag, "_err"},      err_v[0], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0]    seq [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
  logic [DW-1:0] dd  [4];

  initial begin
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 3; r++) exp_rd[k][r] = '0;
    rst = 1'b1; en = 1'b0; muxcode = 2'd0; addr = '0; mem_rdata = '0;
    for (int j = 0; j < 4; j++) dd[j] = {$urandom, $urandom};
    repeat (3) tick();
    check_reset_vals("reset");

    // Single d read issued on the first edge after reset release
    tick(); rst = 1'b0; en = 1'b1; muxcode = 2'd1; addr = 14'h0A05;
    tick(); en = 1'b0;
    chk("single_mem_en", mem_en_v[0], 1'b1);
    chk("single_mem_addr", maddr[0], 14'h0A05);
    chk("single_busy_t1", busy_v[0], 1'b1);
    tick();
    chk("single_busy_t2", busy_v[0], 1'b1);
    chk("single_d_rvalid_t2", d_rv[0], 1'b0);
    tick(); mem_rdata = 64'hDEADBEEF;
    chk("single_busy_t3", busy_v[0], 1'b1);
    tick();
    chk("single_d_rvalid", d_rv[0], 1'b1);
    chk("single_d_rdata", d_rd[0], 64'hDEADBEEF);
    chk("single_i_rdata", i_rd[0], '0);
    chk("single_c_rdata", c_rd[0], '0);
    chk("single_busy_t4", busy_v[0], 1'b1);
    tick();
    chk("single_d_rvalid_t5", d_rv[0], 1'b0);
    chk("single_busy_t5", busy_v[0], 1'b0);
    chk("single_d_hold", d_rd[0], 64'hDEADBEEF);

    // Streaming i, c, d, i back to back
    for (int k = 0; k < 10; k++) begin
      tick();
      en      = (k < 4);
      muxcode = (k < 4) ? seq[k] : 2'd0;
      addr    = A'($urandom);
      if (k >= 3 && k <= 6) mem_rdata = dd[k-3];
      if (k >= 4 && k <= 7) begin
        chk("strm_i_rvalid", i_rv[0], seq[k-4] == 2'd0);
        chk("strm_d_rvalid", d_rv[0], seq[k-4] == 2'd1);
        chk("strm_c_rvalid", c_rv[0], seq[k-4] == 2'd2);
        chk("strm_onehot", 64'($countones({i_rv[0], d_rv[0], c_rv[0]})), 1);
        case (seq[k-4])
          2'd0:    chk("strm_i_rdata", i_rd[0], dd[k-4]);
          2'd1:    chk("strm_d_rdata", d_rd[0], dd[k-4]);
          default: chk("strm_c_rdata", c_rd[0], dd[k-4]);
        endcase
      end
      if (k == 7) chk("strm_busy_last", busy_v[0], 1'b1);
      if (k == 8) chk("strm_busy_fall", busy_v[0], 1'b0);
    end

    // Hold: c read returns 0x1234, then data bus churns
    for (int k = 0; k < 15; k++) begin
      tick();
      en = (k == 0); muxcode = 2'd2;
      if (k == 3) mem_rdata = 64'h1234;
      if (k == 4) begin
        chk("hold_c_rvalid_pulse", c_rv[0], 1'b1);
        chk("hold_c_rdata_load", c_rd[0], 64'h1234);
      end
      if (k >= 5) begin
        chk("hold_c_rvalid", c_rv[0], 1'b0);
        chk("hold_c_rdata", c_rd[0], 64'h1234);
      end
    end

    // Illegal code: dropped, err sticks
    tick(); en = 1'b1; muxcode = 2'd3; addr = 14'h1FFF;
    tick(); en = 1'b0; muxcode = 2'd0;
    chk("illegal_mem_en", mem_en_v[0], 1'b0);
    chk("illegal_err_rise", err_v[0], 1'b1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("illegal_err_sticky", err_v[0], 1'b1);
      chk("illegal_busy", busy_v[0], 1'b0);
      chk("illegal_no_rvalid", {i_rv[0], d_rv[0], c_rv[0]}, 3'b000);
    end

    // Reset mid-flight: three reads, then async reset for two cycles
    for (int k = 0; k < 3; k++) begin
      tick(); en = 1'b1; muxcode = 2'(k); addr = A'($urandom);
    end
    tick(); en = 1'b0; rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    chk("async_rst_busy_l8", busy_v[2], 1'b0);
    tick();
    tick(); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("postrst_no_rvalid", {i_rv, d_rv, c_rv}, '0);
      chk("postrst_busy", busy_v, 3'b000);
    end

    // Random legal/idle traffic across all three latencies
    for (int k = 0; k < 300; k++) begin
      tick();
      en      = ($urandom_range(0, 99) < 60);
      muxcode = 2'($urandom_range(0, 2));
      addr    = A'($urandom);
    end
    tick(); en = 1'b0;
    repeat (15) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
